// File: rtl/multicycle_control.sv
// Multicycle control FSM for a RISC-V style datapath.
// It sequences FETCH / DECODE / EXECUTE / MEM / WRITEBACK and drives the
// datapath strobes. It counts retired instructions. An opcode it does not
// recognise parks the FSM in TRAP, and only reset releases it.
module multicycle_control #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 imem_valid,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_imm,
  output logic [2:0]           instruction_type,
  output logic [2:0]           state,
  output logic                 illegal_instr,
  output logic [31:0]          instr_count
);

  // FSM state encodings
  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  // Instruction format encodings
  localparam logic [2:0] T_R = 3'b000;
  localparam logic [2:0] T_I = 3'b001;
  localparam logic [2:0] T_S = 3'b010;
  localparam logic [2:0] T_U = 3'b011;
  localparam logic [2:0] T_B = 3'b100;
  localparam logic [2:0] T_J = 3'b101;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0] opcode_q;
  logic [2:0] next_state;
  logic [2:0] decoded_type;
  logic       decode_legal;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;

  // Only the opcode field matters to the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[WORD_SIZE-1:7];

  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_jal    = (opcode_q == OP_JAL);
  assign is_jalr   = (opcode_q == OP_JALR);

  // Map the latched opcode to its format and decide whether it is legal
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    decoded_type = T_R;
    decode_legal = 1'b1;
    case (opcode_q)
      OP_REG:                   decoded_type = T_R;
      OP_IMM, OP_JALR, OP_LOAD: decoded_type = T_I;
      OP_STORE:                 decoded_type = T_S;
      OP_LUI, OP_AUIPC:         decoded_type = T_U;
      OP_BRANCH:                decoded_type = T_B;
      OP_JAL:                   decoded_type = T_J;
      default:                  decode_legal = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     next_state = imem_valid ? S_DECODE : S_FETCH;
      S_DECODE:    next_state = decode_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_branch)                next_state = S_FETCH;
        else if (is_load || is_store) next_state = S_MEM;
        else                          next_state = S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ready) next_state = is_store ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: next_state = S_FETCH;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_FETCH;
    endcase
  end

  // Datapath strobes, all forced low while reset is held
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src_imm = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_valid;
        end
        S_EXECUTE: begin
          alu_src_imm = (instruction_type != T_R) && (instruction_type != T_B);
          if (is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          pc_write = is_store && dmem_ready;
        end
        S_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (is_jal)       pc_src = 2'b01;
          else if (is_jalr) pc_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Latched opcode, instruction type, trap flag and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q         <= 7'd0;
      instruction_type <= T_R;
      illegal_instr    <= 1'b0;
      instr_count      <= 32'd0;
    end else begin
      if (state == S_FETCH && imem_valid) opcode_q <= instruction[6:0];
      if (state == S_DECODE) begin
        if (decode_legal) instruction_type <= decoded_type;
        else              illegal_instr    <= 1'b1;
      end
      // pc_write marks the final cycle of every retiring instruction.
      if (pc_write) instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WORD_SIZE, 32, instruction width in bits.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: instruction  input  WORD_SIZE  instruction memory read data; sampled only when imem_valid=1 in FETCH.
REQ-006 Port: imem_valid  input  1  instruction memory response valid.
REQ-007 Port: dmem_ready  input  1  data memory access complete.
REQ-008 Port: branch_taken  input  1  ALU branch comparison result; sampled in EXECUTE.
REQ-009 Port: imem_req  output  1  fetch request.
REQ-010 Port: ir_write  output  1  instruction register load strobe.
REQ-011 Port: dmem_req / dmem_we  output  1 each  data memory request / write enable.
REQ-012 Port: reg_write  output  1  register file write strobe.
REQ-013 Port: pc_write  output  1  PC update strobe.
REQ-014 Port: pc_src  output  2  00=PC+4, 01=PC+imm (branch/jal), 10=rs1+imm (jalr).
REQ-015 Port: alu_src_imm  output  1  ALU operand B select immediate.
REQ-016 Port: instruction_type  output  3  latched type; R=000, I=001, S=010, U=011, B=100, J=101.
REQ-017 Port: state  output  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
REQ-018 Port: illegal_instr  output  1  sticky illegal-opcode flag.
REQ-019 Port: instr_count  output  32  retired-instruction counter.

Function
REQ-020 FETCH SHALL hold imem_req=1 until imem_valid=1; in that cycle ir_write=1, opcode instruction[6:0] is latched internally, next state DECODE; imem_valid outside FETCH SHALL be ignored.
REQ-021 DECODE (one cycle) SHALL map the latched opcode: op->R; op_imm, jalr, load->I; store->S; lui, auipc->U; branch->B; jal->J; any other opcode -> TRAP, else EXECUTE.
REQ-022 EXECUTE (one cycle): alu_src_imm=1 for all types except R and B; branch SHALL assert pc_write=1 with pc_src=01 if branch_taken else 00, then FETCH; load/store -> MEM; all others -> WRITEBACK.
REQ-023 MEM SHALL hold dmem_req=1 (dmem_we=1 for store) until dmem_ready=1; store then asserts pc_write=1, pc_src=00, -> FETCH; load -> WRITEBACK.
REQ-024 WRITEBACK (one cycle) SHALL assert reg_write=1 and pc_write=1, pc_src=01 for jal, 10 for jalr, 00 otherwise, -> FETCH.
REQ-025 pc_write SHALL pulse exactly once per retired instruction, in its final cycle; instr_count SHALL increment by 1 on that edge, wrapping 0xFFFFFFFF->0.
REQ-026 TRAP SHALL be absorbing until reset: illegal_instr=1, all request/strobe outputs 0, instr_count frozen.
REQ-027 All strobes (ir_write, reg_write, pc_write, dmem_req, dmem_we, imem_req) SHALL be 0 in states not listed as asserting them.
REQ-028 Latency with one-cycle memory responses: branch 3, R/I/U/J/jalr 4, store 4, load 5 cycles, FETCH entry to FETCH re-entry.

Reset
REQ-029 Reset SHALL take priority over all inputs in every state including MEM and TRAP.
REQ-030 On the edge with reset=1: state=FETCH, instruction_type=000, illegal_instr=0, instr_count=0, latched opcode=0; all strobes 0 during reset.
REQ-031 Reset mid-MEM SHALL drop dmem_req next cycle with no pc_write and no count increment.
REQ-032 First cycle after reset release SHALL be FETCH with imem_req=1.

Verification
REQ-033 ADD 0x002081B3, imem_valid at cycle 0 -> ir_write c0, DECODE c1, EXECUTE c2 alu_src_imm=0, c3 reg_write=1 pc_write=1 pc_src=00, instr_count=1 at c4.
REQ-034 LW 0x0000A103, dmem_ready low 2 cycles in MEM -> dmem_req=1 dmem_we=0 c3-c5, WRITEBACK c6 reg_write=1, instruction_type=001.
REQ-035 SW 0x0020A023, dmem_ready at c3 -> dmem_we=1 c3, pc_write=1 c3, reg_write never 1, next FETCH c4.
REQ-036 BEQ 0x00208463 twice, branch_taken=1 then 0 -> pc_write at EXECUTE with pc_src=01 then 00, no reg_write, instr_count=2.
REQ-037 JALR 0x000080E7 -> WRITEBACK pc_src=10 reg_write=1; JAL 0x008000EF -> pc_src=01, instruction_type=101.
REQ-038 Opcode 0x7F -> state=5 from c2, illegal_instr=1, imem_req stays 0 for 20 cycles; reset -> FETCH, illegal_instr=0, instr_count=0.
